mac_sequencer: RTL and testbench

Dot-product sequencer wrapped around the team's shift-add multiplier core.
- Accepts a stream of N-bit operand pairs and launches one multiplication per pair.
- Collects each 2N-bit product and accumulates LEN products into an ACC_W-bit sum.
- Presents the sum on a valid/ready output port.
- Sits directly upstream (drives start/operands) and downstream (consumes ready/product) of the multiplier.

---
 rtl/mac_sequencer.sv | 123 ++++++++++++
 tb/tb_mac_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: feeds operand pairs to an external shift-add multiplier
// and accumulates LEN products into an ACC_W-bit sum with a sticky overflow flag.
module mac_sequencer #(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int LEN   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    output logic               mul_start,
    output logic [N-1:0]       mul_multiplier,
    output logic [N-1:0]       mul_multiplicand,
    input  logic               mul_ready,
    input  logic [2*N-1:0]     mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf
);

    generate
        if (ACC_W < 2 * N) begin : g_bad_acc_w
            $error("mac_sequencer: ACC_W must be at least 2*N");
        end
        if (LEN < 1) begin : g_bad_len
            $error("mac_sequencer: LEN must be at least 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               ovf_reg, ovf_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]       a_reg, a_next;
    logic [N-1:0]       b_reg, b_next;
    logic [ACC_W:0]     sum_wide;
    logic [CNT_W-1:0]   cnt_inc;

    // Extra top bit captures the carry out of the accumulator for the sticky flag.
    assign sum_wide = {1'b0, acc_reg} + {{(ACC_W + 1 - 2 * N){1'b0}}, mul_product};
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        in_ready   = 1'b0;
        mul_start  = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_next     = in_a;
                    b_next     = in_b;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    acc_next   = sum_wide[ACC_W-1:0];
                    ovf_next   = ovf_reg | sum_wide[ACC_W];
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == CNT_W'(LEN)) ? OUT : IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mul_multiplier   = a_reg;
    assign mul_multiplicand = b_reg;
    assign out_sum          = acc_reg;
    assign out_ovf          = ovf_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: two sequencers (ACC_W=16 and ACC_W=8) run in lockstep, with the
// multiplier core's done pulse and product driven by hand from the stimulus.
module tb_mac_sequencer;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic             mul_ready = 1'b0;
    logic [2*N-1:0]   mul_product = '0;
    logic             out_ready = 1'b0;

    logic             in_ready, mul_start, out_valid, out_ovf;
    logic [N-1:0]     mul_multiplier, mul_multiplicand;
    logic [15:0]      out_sum;

    logic             in_ready8, mul_start8, out_valid8, out_ovf8;
    logic [N-1:0]     mul_multiplier8, mul_multiplicand8;
    logic [7:0]       out_sum8;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    mac_sequencer #(.N(N), .ACC_W(16), .LEN(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_multiplier(mul_multiplier),
        .mul_multiplicand(mul_multiplicand),
        .mul_ready(mul_ready), .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    mac_sequencer #(.N(N), .ACC_W(8), .LEN(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start8), .mul_multiplier(mul_multiplier8),
        .mul_multiplicand(mul_multiplicand8),
        .mul_ready(mul_ready), .mul_product(mul_product),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_ovf(out_ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_start === 1'b1) starts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".mul_start"}, mul_start, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out_sum"}, out_sum, 0);
        chk({tag, ".out_ovf"}, out_ovf, 0);
        chk({tag, ".mul_multiplier"}, mul_multiplier, 0);
        chk({tag, ".mul_multiplicand"}, mul_multiplicand, 0);
        chk({tag, ".out_sum8"}, out_sum8, 0);
    endtask

    // Offers a pair, waits for the handshake, then answers as the multiplier after m cycles.
    task automatic send_pair(input int a, input int b, input int m, input bit keep_valid);
        int n;
        int starts_before;
        in_a = N'(a);
        in_b = N'(b);
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_in_ready_timeout", in_ready, 1);
        starts_before = starts;
        tick();
        if (!keep_valid) in_valid = 1'b0;
        $display("pair a=%0d b=%0d accepted at t=%0t", a, b, $time);
        chk("launch.mul_start", mul_start, 1);
        chk("launch.mul_start8", mul_start8, 1);
        chk("launch.in_ready", in_ready, 0);
        chk("launch.mul_multiplier", mul_multiplier, a);
        chk("launch.mul_multiplicand", mul_multiplicand, b);
        tick();
        chk("wait.mul_start_one_cycle", mul_start, 0);
        chk("wait.in_ready", in_ready, 0);
        chk("wait.start_count", starts - starts_before, 1);
        repeat (m - 2) tick();
        mul_ready = 1'b1;
        mul_product = 8'(a * b);
        tick();
        mul_ready = 1'b0;
        mul_product = '0;
        chk("wait.operands_held", mul_multiplier, a);
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("result accepted at t=%0t", $time);
        chk("accept.in_ready", in_ready, 1);
        chk("accept.out_valid", out_valid, 0);
        chk("accept.out_sum", out_sum, 0);
        chk("accept.out_ovf8", out_ovf8, 0);
    endtask

    initial begin
        int starts_base;
        logic [15:0] held_sum;

        // Reset
        repeat (3) tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();
        chk_reset_state("post_reset_idle");

        // Basic dot product: 15 + 14 + 225 + 0 = 254
        starts_base = starts;
        send_pair(3, 5, 2, 1'b0);
        chk("basic.idle_after_1", in_ready, 1);
        chk("basic.partial_sum", out_sum, 15);
        send_pair(2, 7, 3, 1'b0);
        send_pair(15, 15, 4, 1'b0);
        send_pair(0, 9, 2, 1'b0);
        chk("basic.out_valid", out_valid, 1);
        chk("basic.in_ready", in_ready, 0);
        chk("basic.out_sum", out_sum, 254);
        chk("basic.out_ovf", out_ovf, 0);
        chk("basic.out_sum8", out_sum8, 254);
        chk("basic.out_ovf8", out_ovf8, 0);
        chk("basic.start_pulses", starts - starts_base, 4);

        // Backpressure with a pending pair
        in_a = 4'd15;
        in_b = 4'd15;
        in_valid = 1'b1;
        held_sum = out_sum;
        starts_base = starts;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.out_valid", out_valid, 1);
            chk("bp.out_sum", out_sum, held_sum);
            chk("bp.in_ready", in_ready, 0);
        end
        chk("bp.no_pair_consumed", starts - starts_base, 0);
        accept_result();
        chk("bp.mul_start_idle", mul_start, 0);

        // Overflow: 4 x 225 = 900 -> 132 mod 256 on the 8-bit accumulator
        send_pair(15, 15, 3, 1'b1);
        send_pair(15, 15, 2, 1'b1);
        send_pair(15, 15, 5, 1'b1);
        send_pair(15, 15, 2, 1'b0);
        chk("ovf.out_valid8", out_valid8, 1);
        chk("ovf.out_sum8", out_sum8, 132);
        chk("ovf.out_ovf8", out_ovf8, 1);
        chk("ovf.out_sum16", out_sum, 900);
        chk("ovf.out_ovf16", out_ovf, 0);
        accept_result();

        // Spurious mul_ready in IDLE must not accumulate
        mul_ready = 1'b1;
        mul_product = 8'hFF;
        tick();
        mul_ready = 1'b0;
        mul_product = '0;
        chk("spurious.out_sum", out_sum, 0);
        chk("spurious.in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) send_pair(1, 1, 2 + i, 1'b0);
        chk("after_ovf.out_sum8", out_sum8, 4);
        chk("after_ovf.out_ovf8", out_ovf8, 0);
        chk("after_ovf.out_sum", out_sum, 4);
        accept_result();

        // Reset during WAIT of the third pair
        send_pair(5, 5, 2, 1'b0);
        send_pair(5, 5, 2, 1'b0);
        in_a = 4'd5;
        in_b = 4'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("midrst.in_wait", in_ready, 0);
        rst = 1'b1;
        #1;
        chk_reset_state("midrst.async");
        repeat (3) tick();
        chk_reset_state("midrst.held");
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_pair(1, 2, 3, 1'b0);
        chk("midrst.out_valid", out_valid, 1);
        chk("midrst.out_sum", out_sum, 8);
        chk("midrst.out_ovf", out_ovf, 0);
        chk("midrst.out_sum8", out_sum8, 8);
        accept_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
